gbuff_banked: RTL and testbench

Parametrised, multi-bank successor to the TPU global buffer. Provides one write port and one read port per cycle across interleaved single-port banks. Write port has byte strobes; read port has a ready/valid handshake with fixed 1-cycle latency. A built-in clear sequencer zeroes the array after reset or on request, instead of using a flop-reset array. Sits between the TPU controller/DMA and the systolic array operand/result paths.

---
 rtl/gbuff_banked.sv | 165 ++++++++++++++++
 tb/tb_gbuff_banked.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/gbuff_banked.sv
// Word-interleaved, multi-bank global buffer: one byte-strobed write port and one
// ready/valid read port per cycle, with a row sequencer that zeroes the array.

module gbuff_bank #(
    parameter int WORD_W = 32,
    parameter int ROW_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [ROW_W-1:0]      row,
    input  logic [WORD_W-1:0]     wdata,
    input  logic [WORD_W/8-1:0]   wstrb,
    output logic [WORD_W-1:0]     rdata
);
    localparam int ROWS   = 1 << ROW_W;
    localparam int STRB_W = WORD_W / 8;

    logic [WORD_W-1:0] mem [ROWS];

    // Storage has no reset; the clear sequencer owns zeroing.
    always_ff @(posedge clk) begin
        if (en && we && !rst) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (wstrb[k]) mem[row][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)            rdata <= '0;
        else if (en && !we) rdata <= mem[row];
    end
endmodule

module gbuff_banked #(
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int BANK_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [WORD_W-1:0]     wr_data,
    input  logic [WORD_W/8-1:0]   wr_strb,
    output logic                  wr_ready,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_ready,
    output logic                  rd_valid,
    output logic [WORD_W-1:0]     rd_data
);
    localparam int NUM_BANKS = 1 << BANK_BITS;
    localparam int ROW_W     = ADDR_W - BANK_BITS;
    localparam int STRB_W    = WORD_W / 8;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t             state, state_nxt;
    logic [ROW_W-1:0]   clr_row, clr_row_nxt;
    logic [BANK_BITS-1:0] wr_bank, rd_bank, sel_q;
    logic [ROW_W-1:0]   wr_row, rd_row;
    logic               wr_fire, rd_fire, clearing;

    logic [NUM_BANKS-1:0]                 bank_en, bank_we;
    logic [NUM_BANKS-1:0][ROW_W-1:0]      bank_row;
    logic [NUM_BANKS-1:0][WORD_W-1:0]     bank_wdata, bank_rdata;
    logic [NUM_BANKS-1:0][STRB_W-1:0]     bank_strb;

    assign wr_bank  = wr_addr[BANK_BITS-1:0];
    assign wr_row   = wr_addr[ADDR_W-1:BANK_BITS];
    assign rd_bank  = rd_addr[BANK_BITS-1:0];
    assign rd_row   = rd_addr[ADDR_W-1:BANK_BITS];
    assign wr_fire  = wr_en && wr_ready;
    assign rd_fire  = rd_en && rd_ready;
    assign clearing = (state == CLEAR);

    always_comb begin
        state_nxt   = state;
        clr_row_nxt = clr_row;
        busy        = 1'b0;
        wr_ready    = 1'b0;
        rd_ready    = 1'b0;
        case (state)
            CLEAR: begin
                busy        = 1'b1;
                clr_row_nxt = clr_row + ROW_W'(1);
                if (clr_row == '1) begin
                    state_nxt   = IDLE;
                    clr_row_nxt = '0;
                end
            end
            IDLE: begin
                wr_ready = 1'b1;
                // Write wins a bank conflict; the reader holds its request.
                rd_ready = !(wr_en && (wr_bank == rd_bank));
                if (clr_req) begin
                    state_nxt   = CLEAR;
                    clr_row_nxt = '0;
                end
            end
            default: begin
                state_nxt   = CLEAR;
                clr_row_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_row  <= '0;
            rd_valid <= 1'b0;
            sel_q    <= '0;
        end else begin
            state    <= state_nxt;
            clr_row  <= clr_row_nxt;
            rd_valid <= rd_fire;
            if (rd_fire) sel_q <= rd_bank;
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_en[b]    = 1'b0;
            bank_we[b]    = 1'b0;
            bank_row[b]   = rd_row;
            bank_wdata[b] = wr_data;
            bank_strb[b]  = wr_strb;
            if (clearing) begin
                bank_en[b]    = 1'b1;
                bank_we[b]    = 1'b1;
                bank_row[b]   = clr_row;
                bank_wdata[b] = '0;
                bank_strb[b]  = '1;
            end else if (wr_fire && wr_bank == BANK_BITS'(b)) begin
                bank_en[b]  = 1'b1;
                bank_we[b]  = 1'b1;
                bank_row[b] = wr_row;
            end else if (rd_fire && rd_bank == BANK_BITS'(b)) begin
                bank_en[b]  = 1'b1;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        gbuff_bank #(.WORD_W(WORD_W), .ROW_W(ROW_W)) u_bank (
            .clk   (clk),
            .rst   (rst),
            .en    (bank_en[b]),
            .we    (bank_we[b]),
            .row   (bank_row[b]),
            .wdata (bank_wdata[b]),
            .wstrb (bank_strb[b]),
            .rdata (bank_rdata[b])
        );
    end

    // Bank output registers only move on their own reads, so this holds between reads.
    assign rd_data = bank_rdata[sel_q];
endmodule

// File: tb/tb_gbuff_banked.sv
// Directed bench for gbuff_banked; read data checked by a queue-based scoreboard monitor.

module tb_gbuff_banked;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_req = 1'b0;
    logic        busy;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strb = '0;
    logic        wr_ready;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_data;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    gbuff_banked #(.WORD_W(32), .ADDR_W(8), .BANK_BITS(2)) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_ready(wr_ready), .rd_en(rd_en), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every rd_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: got rd_valid=1 data 0x%08h expected no read at %0t", rd_data, $time);
            end else begin
                chk("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
        @(negedge clk);
        chk("wr_ready", {31'b0, wr_ready}, 32'd1);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [31:0] exp);
        bit done = 0;
        rd_en = 1'b1; rd_addr = a;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (rd_ready) begin
                exp_q.push_back(exp);
                done = 1;
            end
            tick();
        end
        rd_en = 1'b0;
        if (!done) chk("rd_accept_timeout", 32'd0, 32'd1);
    endtask

    // Counts negedges with busy high, starting from the next negedge; inputs are dropped when busy falls.
    task automatic count_busy(output int cnt, output int vld_seen);
        cnt = 0;
        vld_seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rd_valid === 1'b1) vld_seen++;
            if (busy) cnt++;
            else break;
        end
        rd_en = 1'b0;
        wr_en = 1'b0;
        tick();
    endtask

    initial begin
        int cnt, vld;

        // Reset values and power-on clear length
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
        chk("rst_rd_ready", {31'b0, rd_ready}, 32'd0);
        chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("rst_rd_data", rd_data, 32'h0);
        tick();
        rst = 1'b0;
        count_busy(cnt, vld);
        chk("init_clear_len", cnt, 32'd64);
        chk("init_clear_vld", vld, 32'd0);

        do_read(8'h00, 32'h0);
        do_read(8'h7F, 32'h0);
        do_read(8'hFF, 32'h0);

        // Byte strobes
        do_write(8'h05, 32'hAABBCCDD, 4'hF);
        do_write(8'h05, 32'h11223344, 4'b0101);
        do_read(8'h05, 32'hAA22CC44);
        do_write(8'h05, 32'hFFFFFFFF, 4'h0);
        do_read(8'h05, 32'hAA22CC44);

        // Bank conflict: write 0x04 and read 0x08 share bank 0
        do_write(8'h08, 32'hCAFE0008, 4'hF);
        do_write(8'h09, 32'h0B0B0009, 4'hF);
        wr_en = 1'b1; wr_addr = 8'h04; wr_data = 32'h44444444; wr_strb = 4'hF;
        rd_en = 1'b1; rd_addr = 8'h08;
        @(negedge clk);
        chk("conflict_rd_ready", {31'b0, rd_ready}, 32'd0);
        tick();
        wr_en = 1'b0;
        @(negedge clk);
        chk("conflict_retry_ready", {31'b0, rd_ready}, 32'd1);
        exp_q.push_back(32'hCAFE0008);
        tick();
        rd_en = 1'b0;
        @(negedge clk);
        chk("conflict_rd_valid", {31'b0, rd_valid}, 32'd1);
        tick();

        // Different banks proceed together
        wr_en = 1'b1; wr_addr = 8'h04; wr_data = 32'h55555555; wr_strb = 4'hF;
        rd_en = 1'b1; rd_addr = 8'h09;
        @(negedge clk);
        chk("parallel_rd_ready", {31'b0, rd_ready}, 32'd1);
        exp_q.push_back(32'h0B0B0009);
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        chk("parallel_rd_valid", {31'b0, rd_valid}, 32'd1);
        tick();
        do_read(8'h04, 32'h55555555);

        // Back-to-back streaming of 16 reads
        for (int i = 0; i < 16; i++) do_write(8'(i), 32'hD0000000 | i, 4'hF);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr = 8'(i);
            @(negedge clk);
            if (i > 0) chk("stream_gap", {31'b0, rd_valid}, 32'd1);
            chk("stream_rd_ready", {31'b0, rd_ready}, 32'd1);
            exp_q.push_back(32'hD0000000 | i);
            tick();
        end
        rd_en = 1'b0;
        @(negedge clk);
        chk("stream_last_valid", {31'b0, rd_valid}, 32'd1);
        @(negedge clk);
        chk("stream_end_idle", {31'b0, rd_valid}, 32'd0);
        tick();

        // clr_req with a read accepted on the same edge
        do_write(8'h20, 32'h12345678, 4'hF);
        clr_req = 1'b1; rd_en = 1'b1; rd_addr = 8'h20;
        @(negedge clk);
        chk("clr_rd_ready", {31'b0, rd_ready}, 32'd1);
        exp_q.push_back(32'h12345678);
        tick();
        clr_req = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        chk("clr_first_valid", {31'b0, rd_valid}, 32'd1);
        chk("clr_busy", {31'b0, busy}, 32'd1);
        chk("clr_wr_ready", {31'b0, wr_ready}, 32'd0);
        count_busy(cnt, vld);
        chk("clr_len", cnt + 1, 32'd64);
        do_read(8'h20, 32'h0);

        // rst while clr_row == 30; requests during clear must be ignored
        do_write(8'hF0, 32'hDEADBEEF, 4'hF);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (30) tick();
        wr_en = 1'b1; wr_addr = 8'h33; wr_data = 32'hFFFFFFFF; wr_strb = 4'hF;
        rd_en = 1'b1; rd_addr = 8'h32;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy(cnt, vld);
        chk("rst_clear_len", cnt, 32'd64);
        chk("rst_clear_vld", vld, 32'd0);
        do_read(8'hF0, 32'h0);
        do_read(8'h33, 32'h0);

        repeat (3) tick();
        chk("scoreboard_drain", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
